// File: rtl/note_tone_generator_pkg.sv
// Shared constants for the note tone generator: key encodings, half-period table
// and octave-shift encodings.
package note_pkg;

    localparam logic [3:0] KEY_REST = 4'd15;
    localparam int         NUM_KEYS = 16;
    localparam int         HP_W     = 20;

    typedef enum logic [1:0] {
        OCT_NORM     = 2'd0,
        OCT_UP       = 2'd1,
        OCT_DOWN     = 2'd2,
        OCT_NORM_ALT = 2'd3
    } oct_shift_e;

    // Half-period in clocks at 100 MHz; upper octave entries are the lower ones halved.
    localparam logic [HP_W-1:0] HALF_PERIOD [NUM_KEYS] = '{
        20'd191113, 20'd170262, 20'd151686, 20'd143173,
        20'd127551, 20'd113636, 20'd101239,
        20'd95556,  20'd85131,  20'd75843,  20'd71586,
        20'd63775,  20'd56818,  20'd50619,
        20'd47778,  20'd0
    };

endpackage

// File: rtl/note_tone_generator_if.sv
// Note request / buzzer status bundle between the note source and the tone generator.
interface note_tone_generator_if;
    logic       key_on;
    logic [3:0] key;
    logic [1:0] oct_shift;
    logic [1:0] vol;
    logic       speaker;
    logic       playing;
    logic [3:0] cur_key;

    modport master (
        output key_on, key, oct_shift, vol,
        input  speaker, playing, cur_key
    );

    modport slave (
        input  key_on, key, oct_shift, vol,
        output speaker, playing, cur_key
    );
endinterface

// File: rtl/note_period_rom.sv
// Combinational key/octave to half-period lookup, with the short-period clamp.
module note_period_rom
    import note_pkg::*;
#(
    parameter int PERIOD_SHIFT = 0,
    parameter int CNT_W        = 20
) (
    input  logic [3:0]       key,
    input  logic [1:0]       oct_shift,
    output logic [CNT_W-1:0] hp
);

    logic [CNT_W-1:0] table_w [NUM_KEYS];
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] shifted;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_table
            assign table_w[gi] = CNT_W'(HALF_PERIOD[gi] >> PERIOD_SHIFT);
        end
    endgenerate

    always_comb begin
        base    = table_w[key];
        shifted = base;
        case (oct_shift_e'(oct_shift))
            OCT_UP:   shifted = base >> 1;
            OCT_DOWN: shifted = base << 1;
            default:  shifted = base;
        endcase
        // A half-period of 1 would leave no cycle for the reload; hold it at 2.
        hp = (shifted == CNT_W'(1)) ? CNT_W'(2) : shifted;
    end

endmodule

// File: rtl/note_tone_generator.sv
// Square-wave buzzer driver: rising key_on starts a note, the half-period counter
// toggles the phase, and a free-running PWM counter gates volume inside the high phase.
module note_tone_generator
    import note_pkg::*;
#(
    parameter int PERIOD_SHIFT = 0,
    parameter int CNT_W        = 20,
    parameter int PWM_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    note_tone_generator_if.slave bus
);

    logic             key_on_q_reg;
    logic             armed_reg;
    logic [3:0]       cur_key_reg;
    logic [CNT_W-1:0] hp_reg;
    logic [CNT_W-1:0] counter_reg;
    logic             phase_reg;
    logic             playing_reg;
    logic [PWM_W-1:0] pwm_cnt_reg;
    logic             speaker_reg;

    logic [CNT_W-1:0] hp_next;
    logic [PWM_W:0]   thresh;
    logic             gate;
    logic             start;

    note_period_rom #(
        .PERIOD_SHIFT (PERIOD_SHIFT),
        .CNT_W        (CNT_W)
    ) u_rom (
        .key       (bus.key),
        .oct_shift (bus.oct_shift),
        .hp        (hp_next)
    );

    // armed_reg only rises once key_on has been seen low after reset, so a gate
    // already high when reset releases cannot masquerade as a rising edge.
    assign start = bus.key_on & ~key_on_q_reg & armed_reg;

    always_comb begin
        thresh = '0;
        case (bus.vol)
            2'd1:    thresh = (PWM_W+1)'(1) << (PWM_W-2);
            2'd2:    thresh = (PWM_W+1)'(1) << (PWM_W-1);
            2'd3:    thresh = (PWM_W+1)'(1) << PWM_W;
            default: thresh = '0;
        endcase
        gate = ({1'b0, pwm_cnt_reg} < thresh);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_on_q_reg <= 1'b0;
            armed_reg    <= 1'b0;
            cur_key_reg  <= KEY_REST;
            hp_reg       <= '0;
            counter_reg  <= '0;
            phase_reg    <= 1'b0;
            playing_reg  <= 1'b0;
            pwm_cnt_reg  <= '0;
            speaker_reg  <= 1'b0;
        end else begin
            key_on_q_reg <= bus.key_on;
            pwm_cnt_reg  <= pwm_cnt_reg + PWM_W'(1);
            speaker_reg  <= playing_reg & phase_reg & gate;
            if (!bus.key_on) begin
                armed_reg <= 1'b1;
            end

            // Start has priority over the counter wrap and always restarts high.
            if (start) begin
                cur_key_reg <= bus.key;
                hp_reg      <= hp_next;
                counter_reg <= hp_next - CNT_W'(1);
                phase_reg   <= 1'b1;
                playing_reg <= (bus.key != KEY_REST);
            end else if (!bus.key_on) begin
                playing_reg <= 1'b0;
                phase_reg   <= 1'b0;
                counter_reg <= '0;
            end else if (playing_reg) begin
                if (counter_reg == '0) begin
                    counter_reg <= hp_reg - CNT_W'(1);
                    phase_reg   <= ~phase_reg;
                end else begin
                    counter_reg <= counter_reg - CNT_W'(1);
                end
            end
        end
    end

    assign bus.speaker = speaker_reg;
    assign bus.playing = playing_reg;
    assign bus.cur_key = cur_key_reg;

endmodule
